// File: rtl/fp_addsub_result_buffer_if.sv
// Handshake/data bundle between the add/sub ALU (producer), the result
// buffer, and the downstream consumer.
//   in_*  : producer -> buffer valid/ready channel carrying {result, exception, op}
//   out_* : buffer -> consumer valid/ready channel plus head classification flags
// master: the environment side (drives in_* data/valid and out_ready)
// slave : the buffer side
interface fp_addsub_result_buffer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_exception;
    logic        in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_exception;
    logic        out_op;
    logic        out_is_zero;
    logic        out_is_neg;

    modport master (
        output in_valid, in_result, in_exception, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_exception, out_op,
               out_is_zero, out_is_neg
    );

    modport slave (
        input  in_valid, in_result, in_exception, in_op, out_ready,
        output in_ready, out_valid, out_result, out_exception, out_op,
               out_is_zero, out_is_neg
    );
endinterface

// File: rtl/fp_addsub_result_buffer.sv
// Result buffer behind the IEEE-754 single-precision add/sub ALU.
// Captures {result, exception, op} into a DEPTH-entry valid/ready FIFO,
// presents the head entry with zero/negative flags, and keeps a saturating
// count of accepted exception results.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of FIFO contents (exception counter kept)
//   bus        slave side of fp_addsub_result_buffer_if (in_*/out_* channels)
//   level      number of stored entries
//   exc_count  accepted entries with exception set, saturating
module fp_addsub_result_buffer #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned EXC_CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    fp_addsub_result_buffer_if.slave bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [EXC_CNT_W-1:0]     exc_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    // Entry layout: {exception, op, result}
    logic [33:0]          mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [EXC_CNT_W-1:0] exc_count_q, exc_count_d;

    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        wr_en;
    logic [33:0] head;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign push  = bus.in_valid & ~full;
    assign pop   = ~empty & bus.out_ready;
    // A push during flush is discarded, so skip the storage write too.
    assign wr_en = push & ~flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        exc_count_d = exc_count_q;

        // The counter tracks accepted handshakes, including ones in a flush cycle.
        if (push && bus.in_exception && (exc_count_q != '1)) begin
            exc_count_d = exc_count_q + EXC_CNT_W'(1);
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                level_d = level_q + LVL_W'(1);
            end else if (pop && !push) begin
                level_d = level_q - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            exc_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            exc_count_q <= exc_count_d;
        end
    end

    // Storage needs no reset; an empty FIFO masks its contents at the outputs.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {bus.in_exception, bus.in_op, bus.in_result};
        end
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        bus.out_valid     = ~empty;
        bus.out_result    = '0;
        bus.out_exception = 1'b0;
        bus.out_op        = 1'b0;
        bus.out_is_zero   = 1'b0;
        bus.out_is_neg    = 1'b0;
        if (!empty) begin
            bus.out_result    = head[31:0];
            bus.out_op        = head[32];
            bus.out_exception = head[33];
            // +0 and -0 both count as zero; only a nonzero value can be negative.
            bus.out_is_zero   = (head[30:0] == '0);
            bus.out_is_neg    = head[31] & (head[30:0] != '0);
        end
    end

    assign bus.in_ready = ~full;
    assign level        = level_q;
    assign exc_count    = exc_count_q;

endmodule
